// File: rtl/warp_pkg.sv
// Shared definitions for the homography warp pipe: coefficient indices, identity pattern, RGB565 payload.
package warp_pkg;

    localparam int unsigned NUM_COEF = 9;
    localparam int unsigned H00_IDX  = 0;
    localparam int unsigned H01_IDX  = 1;
    localparam int unsigned H02_IDX  = 2;
    localparam int unsigned H10_IDX  = 3;
    localparam int unsigned H11_IDX  = 4;
    localparam int unsigned H12_IDX  = 5;
    localparam int unsigned H20_IDX  = 6;
    localparam int unsigned H21_IDX  = 7;
    localparam int unsigned H22_IDX  = 8;

    // Bit i set means coefficient i resets to 1.0 (H00, H11, H22)
    localparam logic [NUM_COEF-1:0] IDENT_DIAG = 9'b1_0001_0001;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/warp_fifo.sv
// Small synchronous FIFO with full/empty flags; push and pop may coincide in one cycle.
module warp_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/homography_warp_pipe.sv
// Maps controller pixels through a runtime-loadable 3x3 fixed-point homography, issues in-order SRAM
// reads and returns tagged RGB565. Define WARP_OOB_FILL_EN to emit FILL_RGB for out-of-range pixels.
module homography_warp_pipe
    import warp_pkg::*;
#(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned COEF_W   = 24,
    parameter int unsigned FRAC_W   = 12,
    parameter int unsigned SRC_W    = 640,
    parameter int unsigned SRC_H    = 480,
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] FILL_RGB = 16'h0000
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iCOEF_WE,
    input  logic [3:0]         iCOEF_ADDR,
    input  logic [COEF_W-1:0]  iCOEF_DATA,
    input  logic               iSTART,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    output logic               oBUSY,
    output logic               oREQ,
    output logic [COORD_W-1:0] oSRAM_X,
    output logic [COORD_W-1:0] oSRAM_Y,
    input  logic               iREADY,
    input  logic [4:0]         iR,
    input  logic [5:0]         iG,
    input  logic [4:0]         iB,
    output logic               oREADY,
    output logic [COORD_W-1:0] oCON_X,
    output logic [COORD_W-1:0] oCON_Y,
    output logic [4:0]         oR,
    output logic [5:0]         oG,
    output logic [4:0]         oB
);
    localparam int unsigned SUM_W = COEF_W + COORD_W + 3;
    localparam int unsigned DW    = SUM_W + COORD_W;
    localparam int unsigned CNT_W = $clog2(COORD_W);
    localparam int unsigned TAG_W = 2 * COORD_W + 1;
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(64'd1 << FRAC_W);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_ISSUE} state_t;

    state_t                    state;
    logic signed [COEF_W-1:0]  shadow [NUM_COEF];
    logic signed [COEF_W-1:0]  active [NUM_COEF];
    logic [COORD_W-1:0]        cur_x, cur_y, q_x, q_y;
    logic [DW-1:0]             rem_x, rem_y, dvs;
    logic [CNT_W-1:0]          cnt;
    logic                      den_bad, neg_x, neg_y, ovf_x, ovf_y;

    logic signed [SUM_W-1:0]   ex_c, ey_c, num_x_c, num_y_c, den_c;
    logic signed [DW-1:0]      den_sh_c;
    logic                      ge_x_c, ge_y_c, x_hi_c, y_hi_c;
    logic                      fill_c, req_c;
    logic [COORD_W-1:0]        sx_c, sy_c;

    logic                      tag_push_c, tag_pop_c, data_pop_c;
    logic                      tag_full, tag_empty, data_full, data_empty;
    logic [TAG_W-1:0]          tag_din_c, tag_dout;
    rgb565_t                   data_din_c, data_dout, out_rgb_c;

    // Numerators/denominator of the projective transform; FRAC_W cancels in the quotient
    always_comb begin
        ex_c     = SUM_W'($signed({1'b0, cur_x}));
        ey_c     = SUM_W'($signed({1'b0, cur_y}));
        num_x_c  = SUM_W'(active[H00_IDX]) * ex_c + SUM_W'(active[H01_IDX]) * ey_c + SUM_W'(active[H02_IDX]);
        num_y_c  = SUM_W'(active[H10_IDX]) * ex_c + SUM_W'(active[H11_IDX]) * ey_c + SUM_W'(active[H12_IDX]);
        den_c    = SUM_W'(active[H20_IDX]) * ex_c + SUM_W'(active[H21_IDX]) * ey_c + SUM_W'(active[H22_IDX]);
        den_sh_c = DW'(den_c) <<< COORD_W;
        ge_x_c   = (rem_x >= dvs);
        ge_y_c   = (rem_y >= dvs);
        x_hi_c   = ovf_x || (32'(q_x) >= SRC_W);
        y_hi_c   = ovf_y || (32'(q_y) >= SRC_H);
    end

`ifdef WARP_OOB_FILL_EN
    logic oob_c;
    assign oob_c  = den_bad || neg_x || neg_y || x_hi_c || y_hi_c;
    assign fill_c = oob_c;
    assign req_c  = !oob_c;
    assign sx_c   = q_x;
    assign sy_c   = q_y;
`else
    // Out-of-range coordinates clamp to the image; a non-positive denominator maps to the origin
    assign fill_c = 1'b0;
    assign req_c  = 1'b1;
    assign sx_c   = (den_bad || neg_x) ? '0 : (x_hi_c ? COORD_W'(SRC_W - 1) : q_x);
    assign sy_c   = (den_bad || neg_y) ? '0 : (y_hi_c ? COORD_W'(SRC_H - 1) : q_y);
`endif

    assign tag_push_c = (state == S_ISSUE) && !tag_full;
    assign tag_din_c  = {cur_x, cur_y, fill_c};
    assign data_din_c = '{r: iR, g: iG, b: iB};

    // Fill tags retire alone; real tags wait for their SRAM data
    assign tag_pop_c  = !tag_empty && (tag_dout[0] || !data_empty);
    assign data_pop_c = tag_pop_c && !tag_dout[0];
    assign out_rgb_c  = tag_dout[0] ? rgb565_t'(FILL_RGB) : data_dout;

    warp_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk(iCLK), .rst_n(iRST_N), .push(tag_push_c), .din(tag_din_c),
        .pop(tag_pop_c), .dout(tag_dout), .full(tag_full), .empty(tag_empty)
    );

    warp_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_data_fifo (
        .clk(iCLK), .rst_n(iRST_N), .push(iREADY), .din(data_din_c),
        .pop(data_pop_c), .dout(data_dout), .full(data_full), .empty(data_empty)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= S_IDLE;
            for (int i = 0; i < NUM_COEF; i++) begin
                shadow[i] <= IDENT_DIAG[i] ? COEF_ONE : '0;
                active[i] <= IDENT_DIAG[i] ? COEF_ONE : '0;
            end
            cur_x   <= '0;
            cur_y   <= '0;
            q_x     <= '0;
            q_y     <= '0;
            rem_x   <= '0;
            rem_y   <= '0;
            dvs     <= '0;
            cnt     <= '0;
            den_bad <= 1'b0;
            neg_x   <= 1'b0;
            neg_y   <= 1'b0;
            ovf_x   <= 1'b0;
            ovf_y   <= 1'b0;
            oBUSY   <= 1'b0;
            oREQ    <= 1'b0;
            oSRAM_X <= '0;
            oSRAM_Y <= '0;
            oREADY  <= 1'b0;
            oCON_X  <= '0;
            oCON_Y  <= '0;
            oR      <= '0;
            oG      <= '0;
            oB      <= '0;
        end else begin
            oREQ   <= 1'b0;
            oREADY <= 1'b0;
            if (iCOEF_WE && (iCOEF_ADDR < 4'(NUM_COEF))) shadow[iCOEF_ADDR] <= iCOEF_DATA;

            case (state)
                S_IDLE: if (iSTART) begin
                    for (int i = 0; i < NUM_COEF; i++) active[i] <= shadow[i];
                    cur_x <= iX;
                    cur_y <= iY;
                    oBUSY <= 1'b1;
                    state <= S_MULT;
                end
                S_MULT: begin
                    rem_x   <= DW'(num_x_c);
                    rem_y   <= DW'(num_y_c);
                    dvs     <= DW'(den_c) << (COORD_W - 1);
                    den_bad <= den_c[SUM_W-1] || (den_c == '0);
                    neg_x   <= num_x_c[SUM_W-1];
                    neg_y   <= num_y_c[SUM_W-1];
                    ovf_x   <= DW'(num_x_c) >= den_sh_c;
                    ovf_y   <= DW'(num_y_c) >= den_sh_c;
                    cnt     <= '0;
                    state   <= S_DIV;
                end
                // One quotient bit per cycle per axis, MSB first
                S_DIV: begin
                    if (ge_x_c) rem_x <= rem_x - dvs;
                    if (ge_y_c) rem_y <= rem_y - dvs;
                    q_x <= {q_x[COORD_W-2:0], ge_x_c};
                    q_y <= {q_y[COORD_W-2:0], ge_y_c};
                    dvs <= dvs >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(COORD_W - 1)) state <= S_ISSUE;
                end
                S_ISSUE: if (!tag_full) begin
                    oREQ <= req_c;
                    if (req_c) begin
                        oSRAM_X <= sx_c;
                        oSRAM_Y <= sy_c;
                    end
                    oBUSY <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (tag_pop_c) begin
                oREADY <= 1'b1;
                oCON_X <= tag_dout[TAG_W-1 -: COORD_W];
                oCON_Y <= tag_dout[COORD_W:1];
                oR     <= out_rgb_c.r;
                oG     <= out_rgb_c.g;
                oB     <= out_rgb_c.b;
            end
        end
    end

endmodule

// File: tb/tb_homography_warp_pipe.sv
// Scoreboard bench for homography_warp_pipe; honours WARP_OOB_FILL_EN when defined at compile time.
`timescale 1ns/1ps
module tb_homography_warp_pipe;

    localparam int COORD_W = 10;
    localparam int COEF_W  = 24;
    localparam int FRAC_W  = 12;
    localparam int SRC_W   = 640;
    localparam int SRC_H   = 480;
    localparam logic [15:0] FILL_RGB = 16'h0000;
    localparam longint ONE = longint'(1) << FRAC_W;

    typedef struct { int x; int y; } req_t;
    typedef struct { int x; int y; logic [15:0] rgb; } out_t;
    typedef struct { int x; int y; int cyc; } pend_t;

    logic iCLK = 1'b0, iRST_N = 1'b0;
    logic iCOEF_WE = 1'b0;
    logic [3:0] iCOEF_ADDR = '0;
    logic [COEF_W-1:0] iCOEF_DATA = '0;
    logic iSTART = 1'b0;
    logic [COORD_W-1:0] iX = '0, iY = '0;
    logic iREADY = 1'b0;
    logic [4:0] iR = '0, iB = '0;
    logic [5:0] iG = '0;
    logic oBUSY, oREQ, oREADY;
    logic [COORD_W-1:0] oSRAM_X, oSRAM_Y, oCON_X, oCON_Y;
    logic [4:0] oR, oB;
    logic [5:0] oG;

    homography_warp_pipe dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCOEF_WE(iCOEF_WE), .iCOEF_ADDR(iCOEF_ADDR),
        .iCOEF_DATA(iCOEF_DATA), .iSTART(iSTART), .iX(iX), .iY(iY), .oBUSY(oBUSY),
        .oREQ(oREQ), .oSRAM_X(oSRAM_X), .oSRAM_Y(oSRAM_Y), .iREADY(iREADY),
        .iR(iR), .iG(iG), .iB(iB), .oREADY(oREADY), .oCON_X(oCON_X), .oCON_Y(oCON_Y),
        .oR(oR), .oG(oG), .oB(oB)
    );

    initial forever #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_pass = 0, n_total = 0;
    longint sh [9];
    longint act [9];
    req_t  exp_req [$];
    out_t  exp_out [$];
    pend_t pend [$];
    bit sram_hold = 0;
    int req_total = 0, rdy_total = 0, last_req_cyc = 0, last_rdy_cyc = 0, accept_cyc = 0;
    int last_req_x = 0, last_req_y = 0;

    function automatic logic [15:0] rgb_of(input int x, input int y);
        if (x == 100 && y == 50) return 16'hF81F;
        return 16'((x * 37) ^ (y * 101) ^ 16'h5A5A);
    endfunction

    function automatic void set_identity();
        for (int i = 0; i < 9; i++) begin
            sh[i]  = (i == 0 || i == 4 || i == 8) ? ONE : 0;
            act[i] = sh[i];
        end
    endfunction

    // Reference transform with 64-bit integer arithmetic
    function automatic void model(input int x, input int y, output int sx, output int sy, output bit oob);
        longint nx, ny, dn, qx, qy;
        nx = act[0] * x + act[1] * y + act[2];
        ny = act[3] * x + act[4] * y + act[5];
        dn = act[6] * x + act[7] * y + act[8];
        oob = 0; sx = 0; sy = 0;
        if (dn <= 0) begin
            oob = 1;
        end else begin
            qx = nx / dn;
            qy = ny / dn;
            if (nx < 0) begin oob = 1; sx = 0; end
            else if (qx >= SRC_W) begin oob = 1; sx = SRC_W - 1; end
            else sx = int'(qx);
            if (ny < 0) begin oob = 1; sy = 0; end
            else if (qy >= SRC_H) begin oob = 1; sy = SRC_H - 1; end
            else sy = int'(qy);
        end
    endfunction

    // Output monitor plus in-order SRAM responder (latency >= 1)
    initial begin
        pend_t p;
        req_t  r;
        out_t  o;
        forever begin
            @(negedge iCLK);
            iREADY = 1'b0;
            if (iRST_N) begin
                if (oREQ) begin
                    req_total++;
                    last_req_cyc = cyc;
                    last_req_x = int'(oSRAM_X);
                    last_req_y = int'(oSRAM_Y);
                    pend.push_back('{x: int'(oSRAM_X), y: int'(oSRAM_Y), cyc: cyc});
                    n_total++;
                    if (exp_req.size() == 0) begin
                        $display("FAIL sram_req: unexpected request (%0d,%0d), none required", oSRAM_X, oSRAM_Y);
                    end else begin
                        r = exp_req.pop_front();
                        if ({oSRAM_X, oSRAM_Y} !== {10'(r.x), 10'(r.y)})
                            $display("FAIL sram_req: got (%0d,%0d) required (%0d,%0d)", oSRAM_X, oSRAM_Y, r.x, r.y);
                        else n_pass++;
                    end
                end
                if (oREADY) begin
                    rdy_total++;
                    last_rdy_cyc = cyc;
                    n_total++;
                    if (exp_out.size() == 0) begin
                        $display("FAIL result: unexpected result CON(%0d,%0d), none required", oCON_X, oCON_Y);
                    end else begin
                        o = exp_out.pop_front();
                        if ({oCON_X, oCON_Y} !== {10'(o.x), 10'(o.y)} || {oR, oG, oB} !== o.rgb)
                            $display("FAIL result: got CON(%0d,%0d) rgb %h required CON(%0d,%0d) rgb %h",
                                     oCON_X, oCON_Y, {oR, oG, oB}, o.x, o.y, o.rgb);
                        else n_pass++;
                    end
                end
                if (!sram_hold && pend.size() > 0 && pend[0].cyc < cyc) begin
                    p = pend.pop_front();
                    iREADY = 1'b1;
                    {iR, iG, iB} = rgb_of(p.x, p.y);
                end
            end
        end
    end

    task automatic send_pixel(input int x, input int y);
        int sx, sy, n;
        bit oob;
        n = 0;
        @(negedge iCLK);
        while (oBUSY && n < 200) begin @(negedge iCLK); n++; end
        if (oBUSY) begin
            n_total++;
            $display("FAIL send_timeout: oBUSY=%b after %0d cycles, 0 required", oBUSY, n);
            return;
        end
        iSTART = 1'b1; iX = 10'(x); iY = 10'(y);
        for (int i = 0; i < 9; i++) act[i] = sh[i];
        model(x, y, sx, sy, oob);
`ifdef WARP_OOB_FILL_EN
        if (oob) exp_out.push_back('{x: x, y: y, rgb: FILL_RGB});
        else begin
            exp_req.push_back('{x: sx, y: sy});
            exp_out.push_back('{x: x, y: y, rgb: rgb_of(sx, sy)});
        end
`else
        exp_req.push_back('{x: sx, y: sy});
        exp_out.push_back('{x: x, y: y, rgb: rgb_of(sx, sy)});
`endif
        @(posedge iCLK); #1;
        accept_cyc = cyc;
        iSTART = 1'b0;
    endtask

    task automatic write_coef(input int addr, input longint v);
        @(negedge iCLK);
        iCOEF_WE = 1'b1; iCOEF_ADDR = 4'(addr); iCOEF_DATA = COEF_W'(v);
        @(posedge iCLK); #1;
        if (addr < 9) sh[addr] = v;
        iCOEF_WE = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_out.size() != 0 || exp_req.size() != 0) && n < 400) begin @(posedge iCLK); n++; end
        #1;
        n_total++;
        if (exp_out.size() != 0 || exp_req.size() != 0)
            $display("FAIL %s_drain: %0d results outstanding, 0 required", name, exp_out.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        set_identity();
        repeat (3) @(posedge iCLK);
        #1;
        n_total++;
        if ({oBUSY, oREQ, oREADY, oSRAM_X, oSRAM_Y, oCON_X, oCON_Y, oR, oG, oB} !== '0)
            $display("FAIL reset_outputs: got busy=%b req=%b rdy=%b rgb=%h, all zero required", oBUSY, oREQ, oREADY, {oR, oG, oB});
        else n_pass++;
        @(negedge iCLK); iRST_N = 1'b1;
    endtask

    task automatic test_identity();
        int base, n;
        base = req_total; n = 0;
        send_pixel(100, 50);
        while (req_total == base && n < 40) begin @(posedge iCLK); #1; n++; end
        n_total++;
        if (last_req_cyc - accept_cyc != 12)
            $display("FAIL identity_latency: got %0d cycles required 12", last_req_cyc - accept_cyc);
        else n_pass++;
        n_total++;
        if (last_req_x != 100 || last_req_y != 50)
            $display("FAIL identity_coord: got (%0d,%0d) required (100,50)", last_req_x, last_req_y);
        else n_pass++;
        drain("identity");
        n_total++;
        if (oR !== 5'd31 || oG !== 6'd0 || oB !== 5'd31 || oCON_X !== 10'd100 || oCON_Y !== 10'd50)
            $display("FAIL identity_rgb: got R=%0d G=%0d B=%0d CON(%0d,%0d) required R=31 G=0 B=31 CON(100,50)",
                     oR, oG, oB, oCON_X, oCON_Y);
        else n_pass++;
    endtask

    task automatic test_shadow();
        send_pixel(30, 40);
        write_coef(0, 2 * ONE);
        write_coef(4, 2 * ONE);
        write_coef(2, 5 * ONE);
        write_coef(12, 7 * ONE);
        n_total++;
        if (oBUSY !== 1'b1) $display("FAIL shadow_busy: got oBUSY=%b required 1", oBUSY);
        else n_pass++;
        drain("shadow_first");
        n_total++;
        if (last_req_x != 30 || last_req_y != 40)
            $display("FAIL shadow_inflight: got (%0d,%0d) required (30,40)", last_req_x, last_req_y);
        else n_pass++;
        send_pixel(10, 20);
        drain("shadow_next");
        n_total++;
        if (last_req_x != 25 || last_req_y != 40)
            $display("FAIL shadow_next: got (%0d,%0d) required (25,40)", last_req_x, last_req_y);
        else n_pass++;
    endtask

    task automatic test_oob();
        int rbase;
        write_coef(2, 0);
        sram_hold = 1;
        rbase = rdy_total;
        send_pixel(10, 20);
        send_pixel(600, 10);
        repeat (30) @(posedge iCLK);
        #1;
        n_total++;
        if (rdy_total != rbase) $display("FAIL oob_order: got %0d results before data, 0 required", rdy_total - rbase);
        else n_pass++;
        n_total++;
`ifdef WARP_OOB_FILL_EN
        if (last_req_x != 20 || last_req_y != 40)
            $display("FAIL oob_req: got last req (%0d,%0d) required (20,40)", last_req_x, last_req_y);
`else
        if (last_req_x != 639 || last_req_y != 20)
            $display("FAIL oob_req: got last req (%0d,%0d) required (639,20)", last_req_x, last_req_y);
`endif
        else n_pass++;
        sram_hold = 0;
        drain("oob_scale");
        write_coef(6, -ONE);
        send_pixel(5, 5);
        drain("oob_den");
        write_coef(6, 0);
    endtask

    task automatic test_back_to_back();
        int base, rbase, rc, n;
        sram_hold = 1;
        base = req_total;
        for (int i = 0; i < 5; i++) send_pixel(10 + i, 3 + i);
        repeat (20) @(posedge iCLK);
        #1;
        n_total++;
        if (req_total - base != 4) $display("FAIL stall_reqs: got %0d requests required 4", req_total - base);
        else n_pass++;
        n_total++;
        if (oBUSY !== 1'b1) $display("FAIL stall_busy: got oBUSY=%b required 1", oBUSY);
        else n_pass++;
        rbase = rdy_total;
        sram_hold = 0;
        n = 0;
        while (rdy_total == rbase && n < 50) begin @(posedge iCLK); #1; n++; end
        rc = last_rdy_cyc;
        n = 0;
        while (req_total - base < 5 && n < 50) begin @(posedge iCLK); #1; n++; end
        n_total++;
        if (req_total - base != 5 || last_req_cyc != rc + 1)
            $display("FAIL stall_release: got req %0d at cycle %0d required 5 at cycle %0d", req_total - base, last_req_cyc, rc + 1);
        else n_pass++;
        drain("stall");
    endtask

    task automatic test_mid_reset();
        int base;
        sram_hold = 1;
        base = req_total;
        send_pixel(1, 2);
        send_pixel(3, 4);
        send_pixel(5, 6);
        repeat (4) @(posedge iCLK);
        #2;
        n_total++;
        if (req_total - base != 2 || oBUSY !== 1'b1)
            $display("FAIL midrst_setup: got %0d outstanding busy=%b required 2 busy=1", req_total - base, oBUSY);
        else n_pass++;
        iRST_N = 1'b0;
        #1;
        n_total++;
        if ({oBUSY, oREQ, oREADY, oSRAM_X, oSRAM_Y, oCON_X, oCON_Y, oR, oG, oB} !== '0)
            $display("FAIL midrst_outputs: got busy=%b sram(%0d,%0d) con(%0d,%0d), all zero required",
                     oBUSY, oSRAM_X, oSRAM_Y, oCON_X, oCON_Y);
        else n_pass++;
        exp_req.delete();
        exp_out.delete();
        pend.delete();
        set_identity();
        sram_hold = 0;
        @(negedge iCLK); iRST_N = 1'b1;
        send_pixel(7, 9);
        drain("midrst");
        n_total++;
        if (last_req_x != 7 || last_req_y != 9)
            $display("FAIL midrst_identity: got (%0d,%0d) required (7,9)", last_req_x, last_req_y);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_shadow();
        test_oob();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
